// File: rtl/prescale_div_n.sv
// Programmable divide-by-N prescaler: terminal-count tick, toggle output op1 (period 2N), divisor reload via load/ack.
// Optional macro PRESCALE_SYNC_LOAD_EN defers a running reload to the next terminal count (PEND state).
module prescale_div_n #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             ip1,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             div_ack,
    output logic             div_err,
    output logic             tick,
    output logic             op1,
    output logic [WIDTH-1:0] cnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] div_q;
    logic             counting;
    logic             at_tc;
    logic             load_ok;
    logic             load_bad;
    logic             load_now;

    // The cycle that leaves RUN still counts, so a terminal count there fires.
    assign counting = en || (state_reg != IDLE);
    assign at_tc    = counting && (cnt == div_q - WIDTH'(1));
    assign load_ok  = div_load && (div_in != '0);
    assign load_bad = div_load && (div_in == '0);

`ifdef PRESCALE_SYNC_LOAD_EN
    logic [WIDTH-1:0] pend_q;
    logic             defer;
    logic             pend_apply;

    assign defer      = load_ok && en && (state_reg == RUN);
    assign load_now   = load_ok && !defer && (state_reg != PEND);
    assign pend_apply = (state_reg == PEND) && (!en || at_tc);
`else
    assign load_now   = load_ok;
`endif

    always_ff @(posedge ip1 or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            div_q     <= WIDTH'(DEFAULT_DIV);
            op1       <= 1'b0;
            tick      <= 1'b0;
            div_ack   <= 1'b0;
            div_err   <= 1'b0;
`ifdef PRESCALE_SYNC_LOAD_EN
            pend_q    <= '0;
`endif
        end else begin
            tick      <= 1'b0;
            div_ack   <= 1'b0;
            div_err   <= load_bad;
            state_reg <= en ? RUN : IDLE;
            busy      <= en;

            if (load_now) begin
                // Immediate reload suppresses any tick and leaves op1 alone.
                div_q   <= div_in;
                cnt     <= '0;
                div_ack <= 1'b1;
            end else begin
                if (at_tc) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                    op1  <= ~op1;
                end else if (en) begin
                    cnt <= cnt + WIDTH'(1);
                end else begin
                    cnt <= '0;
                end
`ifdef PRESCALE_SYNC_LOAD_EN
                if (load_ok && (defer || state_reg == PEND)) begin
                    pend_q <= div_in;
                end
                if (pend_apply) begin
                    // Tick above still fires; the newest pending divisor takes over.
                    div_q   <= load_ok ? div_in : pend_q;
                    cnt     <= '0;
                    div_ack <= 1'b1;
                end else if (defer || state_reg == PEND) begin
                    state_reg <= PEND;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_prescale_div_n.sv
// Directed bench for prescale_div_n: phase/modulo reference model checked every cycle, plus literal checkpoints.
module tb_prescale_div_n;

    localparam int WIDTH       = 8;
    localparam int DEFAULT_DIV = 2;

    logic             ip1 = 1'b0;
    logic             reset = 1'b0;
    logic             en = 1'b0;
    logic [WIDTH-1:0] div_in = '0;
    logic             div_load = 1'b0;
    logic             div_ack, div_err, tick, op1, busy;
    logic [WIDTH-1:0] cnt;

    int n_vec  = 0;
    int n_fail = 0;

    prescale_div_n #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
        .ip1     (ip1),
        .reset   (reset),
        .en      (en),
        .div_in  (div_in),
        .div_load(div_load),
        .div_ack (div_ack),
        .div_err (div_err),
        .tick    (tick),
        .op1     (op1),
        .cnt     (cnt),
        .busy    (busy)
    );

    always #5 ip1 = ~ip1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase counts enabled cycles since the last restart;
    // a tick is due whenever phase reaches a multiple of N.
    int m_n, phase, m_pend_n;
    bit m_tick, m_op1, m_busy, m_ack, m_err, m_pend;

    task automatic advance(input bit counted);
        if (counted) begin
            phase++;
            if (phase % m_n == 0) begin
                m_tick = 1'b1;
                m_op1  = ~m_op1;
            end
        end
    endtask

    always @(posedge ip1 or negedge reset) begin
        if (!reset) begin
            m_n = DEFAULT_DIV; phase = 0; m_pend_n = 0;
            m_tick = 0; m_op1 = 0; m_busy = 0; m_ack = 0; m_err = 0; m_pend = 0;
        end else begin
            bit counted, ok, fire;
            counted = en || m_busy;
            ok      = div_load && (div_in != 0);
            m_err   = div_load && (div_in == 0);
            m_ack   = 0;
            m_tick  = 0;
            fire    = counted && ((phase + 1) % m_n == 0);
`ifdef PRESCALE_SYNC_LOAD_EN
            if (m_pend) begin
                if (ok) m_pend_n = int'(div_in);
                advance(counted);
                if (!en || fire) begin
                    m_n = m_pend_n; phase = 0; m_ack = 1; m_pend = 0;
                end
            end else if (ok && m_busy && en) begin
                m_pend = 1; m_pend_n = int'(div_in);
                advance(counted);
            end else if (ok) begin
                m_n = int'(div_in); phase = 0; m_ack = 1;
            end else begin
                advance(counted);
            end
`else
            if (ok) begin
                m_n = int'(div_in); phase = 0; m_ack = 1;
            end else begin
                advance(counted);
            end
`endif
            if (fire && !counted) m_tick = 0;
            if (!en) phase = 0;
            m_busy = en;
        end
    end

    always @(negedge ip1) begin
        if (reset) begin
            check("tick",    int'(tick),    int'(m_tick));
            check("op1",     int'(op1),     int'(m_op1));
            check("cnt",     int'(cnt),     phase % m_n);
            check("busy",    int'(busy),    int'(m_busy));
            check("div_ack", int'(div_ack), int'(m_ack));
            check("div_err", int'(div_err), int'(m_err));
        end
    end

    task automatic step(input bit e, input bit ld, input int d);
        en = e; div_load = ld; div_in = WIDTH'(d);
        @(posedge ip1);
        @(negedge ip1);
        $display("step en=%0d load=%0d div_in=%0d -> cnt=%0d tick=%0d op1=%0d ack=%0d err=%0d busy=%0d",
                 e, ld, d, cnt, tick, op1, div_ack, div_err, busy);
        div_load = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cnt"},  int'(cnt),     0);
        check({tag, "_tick"}, int'(tick),    0);
        check({tag, "_op1"},  int'(op1),     0);
        check({tag, "_busy"}, int'(busy),    0);
        check({tag, "_ack"},  int'(div_ack), 0);
        check({tag, "_err"},  int'(div_err), 0);
    endtask

    initial begin
        repeat (3) @(negedge ip1);
        check_all_zero("rst");
        #2 reset = 1'b1;

        // Default divisor 2: ticks on edges 2 and 4.
        step(1, 0, 0); check("t1_cnt_e1", int'(cnt), 1);
        step(1, 0, 0); check("t1_tick_e2", int'(tick), 1); check("t1_op1_e2", int'(op1), 1);
        step(1, 0, 0);
        step(1, 0, 0); check("t1_op1_e4", int'(op1), 0); check("t1_busy", int'(busy), 1);
        step(1, 0, 0);
        // Load 5 at cnt=1 (also a terminal count): load wins.
        step(1, 1, 5);
        check("t2_ack", int'(div_ack), 1); check("t2_tick", int'(tick), 0);
        check("t2_cnt", int'(cnt), 0);     check("t2_op1", int'(op1), 0);
        repeat (5) step(1, 0, 0);
        check("t2_tick5", int'(tick), 1); check("t2_op1_5", int'(op1), 1);

        // Zero divisor rejected; cadence unchanged.
        step(1, 0, 0); step(1, 0, 0);
        step(1, 1, 0); check("t3_err", int'(div_err), 1); check("t3_cnt", int'(cnt), 3);
        step(1, 0, 0);
        step(1, 0, 0); check("t3_tick", int'(tick), 1);

        // N=1 then disable.
        step(1, 1, 1); check("t5_ack", int'(div_ack), 1);
        repeat (4) step(1, 0, 0);
        check("t5_tick", int'(tick), 1); check("t5_op1", int'(op1), 0);
        step(0, 0, 0); check("t5_lasttick", int'(tick), 1); check("t5_busy", int'(busy), 0);
        step(0, 0, 0); check("t5_idle_tick", int'(tick), 0); check("t5_idle_op1", int'(op1), 1);
        step(0, 0, 0); step(0, 0, 0); check("t5_frozen_op1", int'(op1), 1);
        check("t5_idle_cnt", int'(cnt), 0);

        // Reset mid-count with a load in flight.
        step(1, 1, 4);
        step(1, 0, 0); step(1, 0, 0);
        step(1, 1, 7);
`ifdef PRESCALE_SYNC_LOAD_EN
        check("t6_cnt_pre", int'(cnt), 3);
`endif
        #2 reset = 1'b0;
        #1 check_all_zero("t6");
        @(negedge ip1);
        #2 reset = 1'b1;
        step(1, 0, 0); check("t6_cnt_e1", int'(cnt), 1);
        step(1, 0, 0); check("t6_tick_e2", int'(tick), 1);

        // Deferred reload sequence (immediate reloads in the default build).
        step(0, 0, 0); step(0, 0, 0);
        step(1, 1, 4);
        step(1, 0, 0);
        step(1, 1, 3);
        step(1, 1, 6);
`ifdef PRESCALE_SYNC_LOAD_EN
        check("t4_cnt3", int'(cnt), 3); check("t4_noack", int'(div_ack), 0);
        step(1, 0, 0);
        check("t4_tick", int'(tick), 1); check("t4_ack", int'(div_ack), 1);
        repeat (6) step(1, 0, 0);
        check("t4_tick6", int'(tick), 1);
`else
        check("t4_ack_imm", int'(div_ack), 1); check("t4_cnt0", int'(cnt), 0);
        repeat (6) step(1, 0, 0);
        check("t4_tick6", int'(tick), 1);
`endif
        repeat (3) step(1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
